// File: rtl/onchip_burst_adapter_pkg.sv
// Shared types and helpers for the on-chip RAM burst adapter.
//   state_t     : adapter FSM states
//   *_DEF       : default widths for the adapter and its RAM
//   max_burst() : longest burst allowed for a given burstcount width
//   norm_burst(): turns a raw burstcount into a beat count (0 -> 1, clamp to max)
package onchip_burst_adapter_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam int BC_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_t;

  // The top burstcount bit is reserved, so the largest burst is 2**(bc_w-1).
  function automatic int unsigned max_burst(input int unsigned bc_w);
    return 32'd1 << (bc_w - 32'd1);
  endfunction

  function automatic int unsigned norm_burst(input int unsigned bc,
                                             input int unsigned max_b);
    if (bc == 32'd0) return 32'd1;
    if (bc > max_b)  return max_b;
    return bc;
  endfunction

endpackage

// File: rtl/onchip_burst_addr_gen.sv
// Burst address register for the adapter. Loads the start address when a
// command is accepted and steps once per issued beat after the first.
// Build option ONCHIP_BURST_WRAP_EN: when defined, only the low WRAP_W bits
// step (wrapping inside the aligned MAX_BURST window); otherwise the whole
// address increments and rolls over at 2**ADDR_W.
// Ports:
//   clk, reset : clock, synchronous active-high reset (address -> 0)
//   load       : take start as the new address
//   inc        : advance to the next beat address
//   start      : burst start word address
//   addr       : current beat address (drives the RAM address directly)
module onchip_burst_addr_gen #(
  parameter int ADDR_W = 13,
  parameter int WRAP_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] start,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_inc;

`ifdef ONCHIP_BURST_WRAP_EN
  always_comb begin
    addr_inc = addr;
    addr_inc[WRAP_W-1:0] = addr[WRAP_W-1:0] + WRAP_W'(1);
  end
`else
  assign addr_inc = addr + ADDR_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= start;
    end else if (inc) begin
      addr <= addr_inc;
    end
  end

endmodule

// File: rtl/onchip_burst_adapter.sv
// Avalon-MM bursting slave front-end for a single-port on-chip RAM with a
// 1-cycle read latency. Each accepted beat becomes one registered RAM access.
// Build option ONCHIP_BURST_WRAP_EN selects wrapping bursts (see addr_gen).
//
// Handshake: a command is taken in any cycle where s_waitrequest is low and
// s_read or s_write is high (write wins if both). Write bursts carry their
// first beat with the command; each further cycle with s_write high is one
// more beat, s_write low is a master stall. s_waitrequest is high only while
// a read burst is being issued. s_readdatavalid marks each returned read beat,
// two cycles after the command for the first beat.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   s_address         : burst start word address
//   s_burstcount      : beats in burst (0 -> 1, above MAX_BURST -> MAX_BURST)
//   s_read / s_write  : read command / write command or write beat
//   s_writedata       : write beat data
//   s_byteenable      : write beat byte enables
//   s_waitrequest     : stall to master
//   s_readdata        : read data (pass-through of m_readdata)
//   s_readdatavalid   : s_readdata valid this cycle
//   m_address, m_byteenable, m_chipselect, m_write, m_writedata : registered RAM controls
//   m_readdata        : RAM q, valid the cycle after a read access
module onchip_burst_adapter
  import onchip_burst_adapter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = DATA_W / 8,
  parameter int BC_W   = BC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [BC_W-1:0]   s_burstcount,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [DATA_W-1:0] s_writedata,
  input  logic [BE_W-1:0]   s_byteenable,
  output logic              s_waitrequest,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic [BE_W-1:0]   m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata
);

  localparam int unsigned MAX_B  = max_burst(BC_W);
  localparam int          WRAP_W = $clog2(MAX_B);

  state_t          state, state_next;
  // cnt: reads -> accesses still to issue after the current one;
  //      writes -> beats still to accept.
  logic [BC_W-1:0] cnt, cnt_next;
  logic [BC_W-1:0] bc_norm;
  logic            load, inc, issue, issue_wr;

  assign bc_norm       = BC_W'(norm_burst(32'(s_burstcount), MAX_B));
  assign s_waitrequest = (state == RD_BURST);
  assign s_readdata    = m_readdata;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    inc        = 1'b0;
    issue      = 1'b0;
    issue_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (s_write) begin
          load     = 1'b1;
          issue    = 1'b1;
          issue_wr = 1'b1;
          cnt_next = bc_norm - BC_W'(1);
          if (bc_norm != BC_W'(1)) state_next = WR_BURST;
        end else if (s_read) begin
          load       = 1'b1;
          issue      = 1'b1;
          cnt_next   = bc_norm - BC_W'(1);
          state_next = RD_BURST;
        end
      end
      RD_BURST: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          inc      = 1'b1;
          issue    = 1'b1;
          cnt_next = cnt - BC_W'(1);
        end
      end
      WR_BURST: begin
        // s_read here is a protocol violation and is ignored.
        if (s_write) begin
          inc      = 1'b1;
          issue    = 1'b1;
          issue_wr = 1'b1;
          cnt_next = cnt - BC_W'(1);
          if (cnt == BC_W'(1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt             <= '0;
      m_chipselect    <= 1'b0;
      m_write         <= 1'b0;
      m_byteenable    <= '0;
      m_writedata     <= '0;
      s_readdatavalid <= 1'b0;
    end else begin
      cnt             <= cnt_next;
      m_chipselect    <= issue;
      m_write         <= issue_wr;
      // A read presented to the RAM this cycle returns data next cycle.
      s_readdatavalid <= m_chipselect & ~m_write;
      if (issue_wr) begin
        m_writedata  <= s_writedata;
        m_byteenable <= s_byteenable;
      end else if (issue) begin
        m_byteenable <= '1;
      end
    end
  end

  onchip_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .WRAP_W (WRAP_W)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .inc   (inc),
    .start (s_address),
    .addr  (m_address)
  );

endmodule

// File: tb/tb_onchip_burst_adapter.sv
module tb_onchip_burst_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] s_address;
  logic [3:0]  s_burstcount;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic [12:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  onchip_burst_adapter dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_burstcount(s_burstcount),
    .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata)
  );

  // ---------------- RAM model (1-cycle read latency) ----------------
  logic [31:0] mem     [0:8191];
  logic [31:0] ref_mem [0:8191];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (m_chipselect) begin
      if (m_write) mem[m_address] <= merge(mem[m_address], m_writedata, m_byteenable);
      else         m_readdata <= mem[m_address];
    end
  end

  function automatic logic [12:0] next_addr(input logic [12:0] a);
`ifdef ONCHIP_BURST_WRAP_EN
    logic [2:0] lo;
    lo = a[2:0] + 3'd1;
    return {a[12:3], lo};
`else
    return a + 13'd1;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        wr;
    logic [12:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  logic        win_en = 1'b0;
  int          win_cnt, win_first, win_last, mcyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every RAM access and every returned read beat is popped and compared.
  always @(negedge clk) begin
    acc_t e;
    mcyc++;
    if (!win_en) begin
      win_cnt = 0; win_first = 0; win_last = 0;
    end
    if (mon_en) begin
      if (m_chipselect) begin
        if (acc_q.size() == 0) begin
          check("unexpected_access", {m_write, m_address}, 64'hFFFF);
        end else begin
          e = acc_q.pop_front();
          if (e.wr) check("wr_access", {m_write, m_address, m_writedata, m_byteenable},
                          {e.wr, e.addr, e.data, e.be});
          else      check("rd_access", {m_write, m_address, m_byteenable},
                          {e.wr, e.addr, e.be});
        end
      end
      if (s_readdatavalid) begin
        if (win_en) begin
          if (win_cnt == 0) win_first = mcyc;
          win_last = mcyc;
          win_cnt++;
        end
        if (exp_q.size() == 0) check("unexpected_rdata", s_readdata, 64'hFFFF_FFFF_FFFF);
        else                   check("rdata", s_readdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic        wr;
    logic [12:0] addr;
    logic [3:0]  bc;
    logic [3:0]  be;
    logic [31:0] seed;
    int          beats;   // expected number of RAM accesses
  } vec_t;

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (s_waitrequest && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("wait_ready", s_waitrequest, 0);
  endtask

  task automatic do_cmd(input vec_t v, input int stall_at, input int stall_n);
    logic [12:0] a;
    a = v.addr;
    wait_ready();
    if (v.wr) begin
      for (int i = 0; i < v.beats; i++) begin
        if (i > 0) @(negedge clk);
        if (i == stall_at) begin
          s_write = 1'b0;
          repeat (stall_n) @(negedge clk);
        end
        s_read       = 1'b0;
        s_write      = 1'b1;
        s_address    = v.addr;
        s_burstcount = v.bc;
        s_writedata  = v.seed + 32'(i);
        s_byteenable = v.be;
        acc_q.push_back('{wr: 1'b1, addr: a, data: s_writedata, be: v.be});
        ref_mem[a] = merge(ref_mem[a], s_writedata, v.be);
        a = next_addr(a);
      end
    end else begin
      s_read       = 1'b1;
      s_write      = 1'b0;
      s_address    = v.addr;
      s_burstcount = v.bc;
      s_byteenable = $urandom_range(0, 15);
      for (int i = 0; i < v.beats; i++) begin
        acc_q.push_back('{wr: 1'b0, addr: a, data: 32'h0, be: 4'hF});
        exp_q.push_back(ref_mem[a]);
        a = next_addr(a);
      end
    end
    @(negedge clk);
    s_read  = 1'b0;
    s_write = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((acc_q.size() != 0 || exp_q.size() != 0) && t < 60) begin
      @(negedge clk); t++;
    end
    repeat (3) @(negedge clk);
    check({name, "_acc_left"}, acc_q.size(), 0);
    check({name, "_rd_left"}, exp_q.size(), 0);
    check({name, "_idle"}, s_waitrequest, 0);
    acc_q.delete();
    exp_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  vec_t vecs[$];

  initial begin
    vec_t v;
    logic [12:0] a;

    for (int i = 0; i < 8192; i++) begin
      mem[i]     = 32'hC0DE_0000 | 32'(i);
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    for (int i = 0; i < 4; i++) begin
      mem[16 + i]     = 32'hA0 + 32'(i);
      ref_mem[16 + i] = 32'hA0 + 32'(i);
    end
    mem[5]     = 32'h0;
    ref_mem[5] = 32'h0;

    // {wr, addr, bc, be, seed, beats}
    vecs.push_back('{1'b0, 13'h0010, 4'd4,  4'hF, 32'h0,         4});
    vecs.push_back('{1'b1, 13'h0005, 4'd1,  4'b0101, 32'hDEADBEEF, 1});
    vecs.push_back('{1'b0, 13'h0005, 4'd1,  4'hF, 32'h0,         1});
    vecs.push_back('{1'b0, 13'h0010, 4'd0,  4'hF, 32'h0,         1});
    vecs.push_back('{1'b0, 13'h0100, 4'd15, 4'hF, 32'h0,         8});
    vecs.push_back('{1'b1, 13'h0200, 4'd15, 4'hF, 32'h1000,      8});
    vecs.push_back('{1'b0, 13'h0200, 4'd8,  4'hF, 32'h0,         8});
    vecs.push_back('{1'b0, 13'h0006, 4'd4,  4'hF, 32'h0,         4});
    vecs.push_back('{1'b1, 13'h1FFC, 4'd8,  4'hF, 32'h7700,      8});
    vecs.push_back('{1'b0, 13'h1FFC, 4'd8,  4'hF, 32'h0,         8});
    vecs.push_back('{1'b1, 13'h0040, 4'd2,  4'b1000, 32'h5566_7788, 2});
    vecs.push_back('{1'b0, 13'h0040, 4'd2,  4'hF, 32'h0,         2});
    vecs.push_back('{1'b1, 13'h0050, 4'd0,  4'hF, 32'h1234_5678, 1});
    vecs.push_back('{1'b0, 13'h0050, 4'd1,  4'hF, 32'h0,         1});

    // reset state
    reset = 1'b1; s_read = 1'b0; s_write = 1'b0; s_address = '0;
    s_burstcount = '0; s_writedata = '0; s_byteenable = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_chipselect", m_chipselect, 0);
    check("rst_write", m_write, 0);
    check("rst_address", m_address, 0);
    check("rst_byteenable", m_byteenable, 0);
    check("rst_writedata", m_writedata, 0);
    check("rst_rdvalid", s_readdatavalid, 0);
    check("rst_waitrequest", s_waitrequest, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // table-driven commands
    foreach (vecs[k]) begin
      do_cmd(vecs[k], -1, 0);
      drain($sformatf("vec%0d", k));
    end
    check("bytemask_ram5", ref_mem[5], 32'h00AD00EF);
    check("bytemask_mem5", mem[5], 32'h00AD00EF);

    // stalled write across the top of the address space
    v = '{1'b1, 13'h1FFE, 4'd3, 4'hF, 32'h11, 3};
    a = 13'h1FFE;
    for (int i = 0; i < 3; i++) begin
      ref_mem[a] = 32'h0;
      mem[a]     = 32'h0;
      a = next_addr(a);
    end
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 2) begin s_write = 1'b0; repeat (2) @(negedge clk); end
      s_write = 1'b1; s_address = v.addr; s_burstcount = v.bc; s_byteenable = 4'hF;
      s_writedata = 32'h11 * 32'(i + 1);
      if (i == 0) a = v.addr;
      acc_q.push_back('{wr: 1'b1, addr: a, data: s_writedata, be: 4'hF});
      ref_mem[a] = s_writedata;
      a = next_addr(a);
    end
    @(negedge clk);
    s_write = 1'b0;
    drain("stall_wr");
    check("stall_mem_1ffe", mem[13'h1FFE], 32'h11);
    check("stall_mem_1fff", mem[13'h1FFF], 32'h22);
`ifndef ONCHIP_BURST_WRAP_EN
    check("stall_mem_0000", mem[13'h0000], 32'h33);
`else
    check("stall_mem_1ff8", mem[13'h1FF8], 32'h33);
`endif
    do_cmd('{1'b0, 13'h1FFE, 4'd3, 4'hF, 32'h0, 3}, -1, 0);
    drain("stall_rd");

    // reset in the third cycle of an 8-beat read
    wait_ready();
    s_read = 1'b1; s_address = 13'h0100; s_burstcount = 4'd8;
    for (int i = 0; i < 3; i++) acc_q.push_back('{wr: 1'b0, addr: 13'h0100 + 13'(i), data: 32'h0, be: 4'hF});
    for (int i = 0; i < 2; i++) exp_q.push_back(ref_mem[13'h0100 + 13'(i)]);
    @(negedge clk); s_read = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("midrst_chipselect", m_chipselect, 0);
    check("midrst_rdvalid", s_readdatavalid, 0);
    check("midrst_waitrequest", s_waitrequest, 0);
    reset = 1'b0;
    drain("midrst");
    for (int i = 0; i < 2; i++) begin
      ref_mem[13'h0020 + 13'(i)] = 32'h2000_0000 + 32'(i);
      mem[13'h0020 + 13'(i)]     = 32'h2000_0000 + 32'(i);
    end
    do_cmd('{1'b0, 13'h0020, 4'd2, 4'hF, 32'h0, 2}, -1, 0);
    drain("after_rst");

    // back-to-back 2-beat reads
    win_en = 1'b1;
    do_cmd('{1'b0, 13'h0030, 4'd2, 4'hF, 32'h0, 2}, -1, 0);
    do_cmd('{1'b0, 13'h0032, 4'd2, 4'hF, 32'h0, 2}, -1, 0);
    drain("b2b");
    check("b2b_beats", win_cnt, 4);
    check("b2b_span", win_last - win_first, 4);
    win_en = 1'b0;

    // random bursts
    for (int k = 0; k < 8; k++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = 13'($urandom_range(0, 8191));
      v.bc    = 4'($urandom_range(0, 15));
      v.be    = 4'($urandom_range(1, 15));
      v.seed  = $urandom;
      v.beats = (v.bc == 0) ? 1 : ((v.bc > 8) ? 8 : int'(v.bc));
      do_cmd(v, (v.wr && v.beats > 2) ? 2 : -1, 1);
      drain($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
